// File: rtl/alu_pkt_initiator_pkg.sv
// Shared constants, enums and helpers for the ALU packet initiator.
package alu_pkt_initiator_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned LEN_W         = 16;
  localparam int unsigned RES_W         = 32;
  localparam int unsigned HDR_BYTES     = 4;
  localparam int unsigned MAX_PAYLOAD   = 65531;
  localparam int unsigned ADD_RSP_BYTES = RES_W / DATA_W;

  localparam logic [7:0] OPC_ADD  = 8'hAD;
  localparam logic [7:0] OPC_ECHO = 8'hEC;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BAD_LEN = 2'd1,
    ST_TIMEOUT = 2'd2
  } status_t;

  typedef enum logic [2:0] {
    I_IDLE,
    I_TX_OPCODE,
    I_TX_RSVD,
    I_TX_LEN_LSB,
    I_TX_LEN_MSB,
    I_TX_PAYLOAD,
    I_WAIT_RSP
  } init_state_t;

  // Payload must leave room for the header in the 16-bit length field; ADD needs whole words.
  function automatic logic len_is_bad(input logic [7:0] opc, input logic [LEN_W-1:0] len);
    return (32'(len) > MAX_PAYLOAD) || ((opc == OPC_ADD) && (len[1:0] != 2'b00));
  endfunction

endpackage

// File: rtl/alu_rsp_collector.sv
// Reply side of the initiator: counts rx bytes, assembles the ADD result, passes ECHO bytes through.
module alu_rsp_collector
  import alu_pkt_initiator_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              active_i,
  input  logic              mode_add_i,
  input  logic [LEN_W-1:0]  expect_cnt_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [RES_W-1:0]  result_o,
  output logic              rx_hs_c,
  output logic              rx_done_c
);

  logic [LEN_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             collecting;

  assign rsp_data_o = rx_data_i;
  assign result_o   = result_q;

  always_comb begin
    collecting  = active_i && (rx_cnt_q != expect_cnt_i);
    rx_ready_o  = 1'b1;
    rsp_valid_o = 1'b0;
    rx_cnt_d    = rx_cnt_q;
    result_d    = result_q;
    // Bytes beyond the expected count, or outside a command, are swallowed.
    if (collecting && !mode_add_i) begin
      rx_ready_o  = rsp_ready_i;
      rsp_valid_o = rx_valid_i;
    end
    if (rst_i) rx_ready_o = 1'b0;
    rx_hs_c = collecting && rx_valid_i && rx_ready_o;
    if (clear_i) begin
      rx_cnt_d = '0;
      result_d = '0;
    end else if (rx_hs_c) begin
      rx_cnt_d = rx_cnt_q + LEN_W'(1);
      if (mode_add_i) result_d = {result_q[RES_W-DATA_W-1:0], rx_data_i};
    end
    rx_done_c = (rx_cnt_d == expect_cnt_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_cnt_q <= '0;
      result_q <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: rtl/alu_pkt_initiator.sv
// Host-side master for the UART ALU packet protocol: sends header + payload, collects the reply.
module alu_pkt_initiator
  import alu_pkt_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned DATA_WIDTH     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [7:0]            cmd_opcode_i,
  input  logic [LEN_W-1:0]      cmd_len_i,
  input  logic [DATA_WIDTH-1:0] pay_data_i,
  input  logic                  pay_valid_i,
  output logic                  pay_ready_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [RES_W-1:0]      result_o,
  output logic                  done_o,
  output logic [1:0]            status_o
);

  localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  init_state_t      state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] exp_q, exp_d;
  logic [LEN_W-1:0] pay_cnt_q, pay_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             done_q, done_d;
  status_t          status_q, status_d;
  logic             clear_c, rx_hs_c, rx_done_c;
  logic [LEN_W-1:0] len_field_c;

  assign len_field_c = len_q + LEN_W'(HDR_BYTES);
  assign cmd_ready_o = (state_q == I_IDLE);
  assign done_o      = done_q;
  assign status_o    = status_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    exp_d       = exp_q;
    pay_cnt_d   = pay_cnt_q;
    tmo_d       = tmo_q;
    done_d      = 1'b0;
    status_d    = status_q;
    clear_c     = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = DATA_WIDTH'(op_q);
    pay_ready_o = 1'b0;
    case (state_q)
      I_IDLE: begin
        if (cmd_valid_i) begin
          if (len_is_bad(cmd_opcode_i, cmd_len_i)) begin
            done_d   = 1'b1;
            status_d = ST_BAD_LEN;
          end else begin
            op_d      = cmd_opcode_i;
            len_d     = cmd_len_i;
            exp_d     = (cmd_opcode_i == OPC_ADD) ? LEN_W'(ADD_RSP_BYTES) : cmd_len_i;
            pay_cnt_d = '0;
            tmo_d     = '0;
            clear_c   = 1'b1;
            state_d   = I_TX_OPCODE;
          end
        end
      end
      I_TX_OPCODE: begin
        tx_valid_o = 1'b1;
        if (tx_ready_i) state_d = I_TX_RSVD;
      end
      I_TX_RSVD: begin
        tx_valid_o = 1'b1;
        tx_data_o  = '0;
        if (tx_ready_i) state_d = I_TX_LEN_LSB;
      end
      I_TX_LEN_LSB: begin
        tx_valid_o = 1'b1;
        tx_data_o  = DATA_WIDTH'(len_field_c[7:0]);
        if (tx_ready_i) state_d = I_TX_LEN_MSB;
      end
      I_TX_LEN_MSB: begin
        tx_valid_o = 1'b1;
        tx_data_o  = DATA_WIDTH'(len_field_c[15:8]);
        if (tx_ready_i) begin
          state_d = (len_q == '0) ? I_WAIT_RSP : I_TX_PAYLOAD;
          tmo_d   = '0;
        end
      end
      I_TX_PAYLOAD: begin
        tx_valid_o  = pay_valid_i;
        tx_data_o   = pay_data_i;
        pay_ready_o = tx_ready_i;
        if (pay_valid_i && tx_ready_i) begin
          pay_cnt_d = pay_cnt_q + LEN_W'(1);
          if (pay_cnt_d == len_q) begin
            state_d = I_WAIT_RSP;
            tmo_d   = '0;
          end
        end
      end
      I_WAIT_RSP: begin
        // An rx byte in the terminal-count cycle restarts the timer rather than timing out.
        if (rx_hs_c)               tmo_d = '0;
        else if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
        if (rx_done_c) begin
          done_d   = 1'b1;
          status_d = ST_OK;
          state_d  = I_IDLE;
        end else if (!rx_hs_c && (tmo_q == TMO_LAST)) begin
          done_d   = 1'b1;
          status_d = ST_TIMEOUT;
          state_d  = I_IDLE;
        end
      end
      default: state_d = I_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= I_IDLE;
      op_q      <= OPC_ECHO;
      len_q     <= '0;
      exp_q     <= '0;
      pay_cnt_q <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      status_q  <= ST_OK;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      len_q     <= len_d;
      exp_q     <= exp_d;
      pay_cnt_q <= pay_cnt_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      status_q  <= status_d;
    end
  end

  alu_rsp_collector u_collector (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_c),
    .active_i     (state_q != I_IDLE),
    .mode_add_i   (op_q == OPC_ADD),
    .expect_cnt_i (exp_q),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .result_o     (result_o),
    .rx_hs_c      (rx_hs_c),
    .rx_done_c    (rx_done_c)
  );

endmodule

// File: tb/tb_alu_pkt_initiator.sv
// Self-checking bench for alu_pkt_initiator with a behavioural loopback ALU device.
module tb_alu_pkt_initiator;
  import alu_pkt_initiator_pkg::*;

  localparam int unsigned TMO = 50;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  cmd_opcode_i = 8'h00;
  logic [15:0] cmd_len_i = 16'h0;
  logic [7:0]  pay_data_i = 8'h00;
  logic        pay_valid_i = 1'b0;
  logic        pay_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  rsp_data_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        done_o;
  logic [1:0]  status_o;

  always #5 clk = ~clk;

  alu_pkt_initiator #(.TIMEOUT_CYCLES(TMO), .DATA_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_opcode_i(cmd_opcode_i), .cmd_len_i(cmd_len_i),
    .pay_data_i(pay_data_i), .pay_valid_i(pay_valid_i), .pay_ready_o(pay_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .result_o(result_o), .done_o(done_o), .status_o(status_o)
  );

  typedef struct {
    logic [7:0] op;
    int         len;
    bit         silent;
    logic [1:0] st;
  } vec_t;

  int errors = 0;
  int checks = 0;

  byte unsigned pay_q[$], dev_q[$], tx_log[$], rsp_log[$], fixed_pay[$];
  vec_t         vecs[$];
  logic [7:0]   cur_op = 8'h00;
  int           cur_len = 0;
  bit           silent = 1'b0;
  bit           pay_took = 1'b0, rx_took = 1'b0, not_ready_seen = 1'b0;
  bit           prev_stalled = 1'b0;
  logic [7:0]   prev_tx_data = 8'h00;
  int unsigned  cyc = 0;
  int unsigned  done_edge = 0, acc_edge = 0, last_tx_edge = 0, last_rx_edge = 0;
  int           done_cnt = 0, pay_hs = 0;
  logic [1:0]   last_status = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int q_diff(input byte unsigned a[$], input byte unsigned b[$]);
    int n;
    n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) n++;
    return n;
  endfunction

  function automatic void add_vec(input logic [7:0] op, input int len, input bit sil, input logic [1:0] st);
    vec_t v;
    v = '{op, len, sil, st};
    vecs.push_back(v);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Input driver: random stalls, valid held until accepted.
  initial forever begin
    @(posedge clk);
    #1;
    tx_ready_i  = ($urandom_range(0, 3) != 0);
    rsp_ready_i = ($urandom_range(0, 4) != 0);
    if (pay_q.size() == 0) pay_valid_i = 1'b0;
    else if (!pay_valid_i || pay_took) pay_valid_i = ($urandom_range(0, 3) != 0);
    pay_data_i = (pay_q.size() > 0) ? pay_q[0] : 8'h00;
    pay_took = 1'b0;
    if (dev_q.size() == 0) rx_valid_i = 1'b0;
    else if (!rx_valid_i || rx_took) rx_valid_i = ($urandom_range(0, 3) != 0);
    rx_data_i = (dev_q.size() > 0) ? dev_q[0] : 8'h00;
    rx_took = 1'b0;
  end

  // Monitor plus loopback ALU device: echoes payload, or replies with the big-endian word sum.
  initial forever begin
    @(negedge clk);
    if (prev_stalled && tx_valid_o) check("tx_hold", tx_data_o, prev_tx_data);
    prev_stalled = tx_valid_o && !tx_ready_i;
    prev_tx_data = tx_data_o;
    if (!cmd_ready_o) not_ready_seen = 1'b1;
    if (cmd_valid_i && cmd_ready_o) acc_edge = cyc + 1;
    if (pay_valid_i && pay_ready_o) begin
      pay_took = 1'b1;
      pay_hs++;
      if (pay_q.size() > 0) pay_q.delete(0);
    end
    if (tx_valid_o && tx_ready_i) begin
      tx_log.push_back(tx_data_o);
      last_tx_edge = cyc + 1;
      if (!silent && cur_op != OPC_ADD && tx_log.size() > 4) dev_q.push_back(tx_data_o);
      if (!silent && cur_op == OPC_ADD && tx_log.size() == 4 + cur_len) begin
        logic [31:0] sum;
        sum = 0;
        for (int i = 0; i < cur_len / 4; i++)
          sum += {tx_log[4+4*i], tx_log[5+4*i], tx_log[6+4*i], tx_log[7+4*i]};
        for (int i = 3; i >= 0; i--) dev_q.push_back(8'(sum >> (8 * i)));
      end
    end
    if (rx_valid_i && rx_ready_o) begin
      rx_took = 1'b1;
      last_rx_edge = cyc + 1;
      if (dev_q.size() > 0) dev_q.delete(0);
    end
    if (rsp_valid_o && rsp_ready_i) rsp_log.push_back(rsp_data_o);
    if (done_o) begin
      done_cnt++;
      done_edge = cyc;
      last_status = status_o;
    end
  end

  task automatic run_cmd(input logic [7:0] op, input int len, input bit sil,
                         input logic [1:0] exp_st, input string tag);
    byte unsigned pay[$], exp_tx[$];
    logic [31:0] exp_res;
    logic [15:0] lf;
    int d0, t;
    pay = {};
    exp_tx = {};
    if (exp_st != ST_BAD_LEN) begin
      for (int i = 0; i < len; i++) pay.push_back((fixed_pay.size() > i) ? fixed_pay[i] : 8'($urandom));
      lf = 16'(len + 4);
      exp_tx.push_back(op);
      exp_tx.push_back(8'h00);
      exp_tx.push_back(lf[7:0]);
      exp_tx.push_back(lf[15:8]);
      foreach (pay[i]) exp_tx.push_back(pay[i]);
    end
    exp_res = 0;
    if (op == 8'hAD && exp_st == ST_OK)
      for (int i = 0; i < len / 4; i++) exp_res += {pay[4*i], pay[4*i+1], pay[4*i+2], pay[4*i+3]};
    @(negedge clk);
    cur_op = op; cur_len = len; silent = sil;
    tx_log = {}; rsp_log = {}; not_ready_seen = 1'b0;
    pay_q = pay;
    d0 = done_cnt;
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_opcode_i = op; cmd_len_i = 16'(len);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 400 + 16 * len) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check({tag, " done_pulses"}, done_cnt - d0, 1);
    check({tag, " status"}, last_status, exp_st);
    check({tag, " tx_bytes"}, q_diff(tx_log, exp_tx), 0);
    check({tag, " cmd_ready"}, cmd_ready_o, 1'b1);
    if (op == 8'hAD && exp_st != ST_BAD_LEN) check({tag, " result"}, result_o, exp_res);
    if (op != 8'hAD && exp_st == ST_OK) check({tag, " rsp_bytes"}, q_diff(rsp_log, pay), 0);
    if (exp_st == ST_BAD_LEN) begin
      check({tag, " bad_latency"}, done_edge - acc_edge, 0);
      check({tag, " ready_held"}, not_ready_seen, 1'b0);
    end else if (exp_st == ST_TIMEOUT) begin
      check({tag, " tmo_latency"}, done_edge - last_tx_edge, TMO);
    end else if (op != 8'hAD && len == 0) begin
      check({tag, " len0_latency"}, done_edge - last_tx_edge, 1);
    end else begin
      check({tag, " done_at_last_rx"}, done_edge - last_rx_edge, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, t;
    logic [7:0] op;
    int len;
    logic [1:0] st;

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst cmd_ready", cmd_ready_o, 1'b1);
    check("rst tx_valid", tx_valid_o, 1'b0);
    check("rst pay_ready", pay_ready_o, 1'b0);
    check("rst rsp_valid", rsp_valid_o, 1'b0);
    check("rst result", result_o, 32'h0);
    check("rst done", done_o, 1'b0);
    check("rst status", status_o, 2'd0);

    fixed_pay = {8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07};
    run_cmd(8'hAD, 8, 1'b0, 2'd0, "add8");
    check("add8 result_0C", result_o, 32'h0000000C);
    fixed_pay = {8'h11, 8'h22, 8'h33};
    run_cmd(8'hEC, 3, 1'b0, 2'd0, "echo3");
    fixed_pay = {};

    add_vec(8'hAD, 6,     1'b0, 2'd1);
    add_vec(8'hAD, 4,     1'b1, 2'd2);
    add_vec(8'hEC, 0,     1'b0, 2'd0);
    add_vec(8'hAD, 0,     1'b0, 2'd0);
    add_vec(8'hEC, 65532, 1'b0, 2'd1);
    add_vec(8'hAD, 65532, 1'b0, 2'd1);
    add_vec(8'hEC, 65535, 1'b0, 2'd1);
    add_vec(8'hAD, 3,     1'b0, 2'd1);
    add_vec(8'hAD, 16,    1'b0, 2'd0);
    add_vec(8'h42, 1,     1'b0, 2'd0);
    add_vec(8'hEC, 5,     1'b1, 2'd2);
    add_vec(8'hEC, 17,    1'b0, 2'd0);
    foreach (vecs[i]) run_cmd(vecs[i].op, vecs[i].len, vecs[i].silent, vecs[i].st, $sformatf("vec%0d", i));

    // Reset in the middle of a payload transfer.
    @(negedge clk);
    cur_op = 8'hAD; cur_len = 64; silent = 1'b1; tx_log = {};
    pay_q = {};
    for (int i = 0; i < 64; i++) pay_q.push_back(8'($urandom));
    pay_hs = 0;
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_opcode_i = 8'hAD; cmd_len_i = 16'd64;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    t = 0;
    while (pay_hs < 5 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid reached_payload", (pay_hs >= 5) ? 1 : 0, 1);
    d0 = done_cnt;
    @(posedge clk); #1;
    rst_i = 1'b1;
    pay_q = {};
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_mid cmd_ready", cmd_ready_o, 1'b1);
    check("rst_mid tx_valid", tx_valid_o, 1'b0);
    check("rst_mid done", done_o, 1'b0);
    repeat (10) @(negedge clk);
    check("rst_mid no_done", done_cnt - d0, 0);
    run_cmd(8'hAD, 8, 1'b0, 2'd0, "after_rst");

    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 2))
        0:       op = 8'hAD;
        1:       op = 8'hEC;
        default: op = 8'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0)          len = 65532 + int'($urandom_range(0, 3));
      else if (op == 8'hAD && $urandom_range(0, 1) == 1) len = 4 * int'($urandom_range(0, 5));
      else                                    len = int'($urandom_range(0, 20));
      st = (len > 65531 || (op == 8'hAD && (len % 4) != 0)) ? 2'd1 : 2'd0;
      run_cmd(op, len, 1'b0, st, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pkt_initiator.md
Name: alu_pkt_initiator

Overview:
Host-side master for the UART ALU packet protocol: accepts a command (opcode, payload length, payload byte stream), serializes the 4-byte header plus payload onto a byte stream toward a uart_tx, and collects the device's reply from a uart_rx byte stream. ADD replies are 4 bytes, big-endian, and are assembled into a 32-bit result. ECHO replies are forwarded as a byte stream. Used in loopback testbenches and on-chip self-test against the ALU device.

Parameters:
TIMEOUT_CYCLES, 1000000, cycles without a reply byte in WAIT_RSP before aborting with TIMEOUT.
DATA_WIDTH, 8, UART byte width; only 8 is supported.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  high only in IDLE
cmd_opcode_i  in  8  opcode byte; 8'hAD = ADD, any other value = ECHO
cmd_len_i  in  16  payload byte count, excluding header
pay_data_i  in  8  payload byte
pay_valid_i  in  1  payload valid
pay_ready_o  out  1  payload accepted when pay_valid_i && pay_ready_o
tx_data_o  out  8  byte to uart_tx
tx_valid_o  out  1  tx byte valid
tx_ready_i  in  1  uart_tx ready
rx_data_i  in  8  byte from uart_rx
rx_valid_i  in  1  rx byte valid
rx_ready_o  out  1  rx byte consumed
rsp_data_o  out  8  ECHO reply byte
rsp_valid_o  out  1  ECHO reply valid
rsp_ready_i  in  1  ECHO reply consumer ready
result_o  out  32  ADD result; held until next accepted command
done_o  out  1  one-cycle pulse at end of command
status_o  out  2  valid with done_o: 0 OK, 1 BAD_LEN, 2 TIMEOUT

Behaviour:
- Reset values: all valid/ready outputs 0 except cmd_ready_o = 1; result_o = 0; done_o = 0; status_o = 0; state IDLE. Reset mid-operation aborts immediately with no done_o pulse.
- Command accept (IDLE, cmd_valid_i):
  - BAD_LEN if cmd_len_i > 65531, or if opcode = 8'hAD and cmd_len_i[1:0] != 0.
  - BAD_LEN response: done_o pulses the next cycle with status 1; the block stays IDLE and transmits nothing.
  - Otherwise latch opcode and length, set expected reply count (4 for ADD, cmd_len_i for ECHO), clear result_o and counters, go to TX_OPCODE.
- TX FSM: TX_OPCODE -> TX_RSVD -> TX_LEN_LSB -> TX_LEN_MSB -> TX_PAYLOAD -> WAIT_RSP.
  - Each header state drives tx_valid_o = 1 and advances on tx_ready_i.
  - Header bytes in order: opcode, 8'h00, (len+4)[7:0], (len+4)[15:8]. The length field includes the 4 header bytes.
  - tx_data_o must stay stable while tx_valid_o && !tx_ready_i.
- TX_PAYLOAD: combinational pass-through. tx_data_o = pay_data_i, tx_valid_o = pay_valid_i, pay_ready_o = tx_ready_i. Count handshakes; exit when count reaches len. len = 0 goes straight to WAIT_RSP.
- RX path runs concurrently with TX from TX_OPCODE onward, because ECHO bytes return during TX_PAYLOAD.
  - ECHO: rsp_data_o = rx_data_i, rsp_valid_o = rx_valid_i, rx_ready_o = rsp_ready_i (no buffering). rx_cnt increments on each rx handshake.
  - Backpressure on rsp_ready_i can overrun uart_rx; that is the consumer's responsibility.
  - ADD: rx_ready_o = 1 and rsp_valid_o = 0. On each rx handshake, result <= {result[23:0], rx_data_i}, so the first byte received is the MSB.
  - Once rx_cnt equals the expected reply count, or in IDLE, rx_ready_o = 1 and extra bytes are dropped silently.
- WAIT_RSP:
  - If rx_cnt == expected: done_o pulses with status 0 and the block returns to IDLE in the same transition. This check is evaluated with the current cycle's handshake included.
  - Timeout counter clears on every rx handshake and on entry. If it reaches TIMEOUT_CYCLES-1 with no completion, done_o pulses with status 2 and the block returns to IDLE. result_o then holds the partial value.
- Counters: rx_cnt and payload count are 16 bits and cannot wrap (len <= 65531). The timeout counter width is $clog2(TIMEOUT_CYCLES+1) and saturates.
- Simultaneous events: an rx handshake and a timeout terminal count in the same cycle resolve as the handshake (timeout reset, then completion check).

Decomposition:
- config_pkg additions:
  - OPC_ADD = 8'hAD, OPC_ECHO = 8'hEC, HDR_BYTES = 4, MAX_PAYLOAD = 65531.
  - status_t enum {ST_OK, ST_BAD_LEN, ST_TIMEOUT}.
  - init_state_t enum {I_IDLE, I_TX_OPCODE, I_TX_RSVD, I_TX_LEN_LSB, I_TX_LEN_MSB, I_TX_PAYLOAD, I_WAIT_RSP}.
- One sub-module: alu_rsp_collector. It holds the rx_cnt, the result shift register and the ECHO pass-through muxing, with inputs expect_cnt, mode and clear. The TX FSM and the timeout counter stay in the top.

Test Plan:
- ADD, len 8, payload 00 00 00 05 00 00 00 07; loopback device responds 00 00 00 0C -> tx bytes AD 00 0C 00 + payload; result_o = 32'h0000000C, done_o with status 0.
- ECHO (8'hEC), len 3, payload 11 22 33; device echoes while TX is still in progress -> tx EC 00 07 00 11 22 33; rsp stream 11 22 33; done_o with status 0 after the third byte.
- ADD, len 6 -> no tx activity, done_o with status 1 one cycle after accept, cmd_ready_o stays 1.
- ADD, len 4, device silent, TIMEOUT_CYCLES = 50 -> done_o with status 2 exactly 50 cycles after the last payload handshake, returns to IDLE.
- ECHO len 0 -> tx EC 00 04 00 only; done_o with status 0 one cycle after entering WAIT_RSP.
- Assert rst_i during TX_PAYLOAD with random tx_ready_i stalls -> next cycle cmd_ready_o = 1, tx_valid_o = 0, no done_o pulse; a new ADD then completes correctly.
